// File: rtl/hp_chan_sched.sv
// hp_chan_sched: shares one high-pass core between N_CH channels.
// Round-robin grant, credit-limited issue, FWFT result FIFO, drain-safe
// coefficient-bank switching.
//
// Ports
//   i_clk, i_rst      clock, async active-high reset (shared with core)
//   i_ch_valid/data   per-channel sample requests (ch k at k*DATA_W)
//   o_ch_ready        one-hot combinational grant
//   o_hp_valid/data/ch/bank   registered issue to core
//   i_hp_ready        core enable (no grant while low)
//   i_hp_valid/data/ch        core results
//   o_out_valid/data/ch, i_out_ready   FWFT result FIFO
//   i_cfg_we/ch/bank  bank write, applied once that channel drains
//   o_cfg_busy        some bank update still pending
//   o_err             sticky overflow / spurious-return flag
module hp_chan_sched #(
  parameter int N_CH         = 8,
  parameter int DATA_W       = 24,
  parameter int BANK_W       = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int HP_LAT       = 3,
  localparam int CH_W        = $clog2(N_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH-1:0]          i_ch_valid,
  input  logic [N_CH*DATA_W-1:0]   i_ch_data,
  output logic [N_CH-1:0]          o_ch_ready,
  output logic                     o_hp_valid,
  output logic [DATA_W-1:0]        o_hp_data,
  output logic [CH_W-1:0]          o_hp_ch,
  output logic [BANK_W-1:0]        o_hp_bank,
  input  logic                     i_hp_ready,
  input  logic                     i_hp_valid,
  input  logic [DATA_W-1:0]        i_hp_data,
  input  logic [CH_W-1:0]          i_hp_ch,
  output logic                     o_out_valid,
  output logic [DATA_W-1:0]        o_out_data,
  output logic [CH_W-1:0]          o_out_ch,
  input  logic                     i_out_ready,
  input  logic                     i_cfg_we,
  input  logic [CH_W-1:0]          i_cfg_ch,
  input  logic [BANK_W-1:0]        i_cfg_bank,
  output logic                     o_cfg_busy,
  output logic                     o_err
);

  localparam int CR_W = $clog2(MAX_INFLIGHT + 1);
  localparam int FA_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int GD_W = $clog2(HP_LAT + 1);

  logic [CH_W-1:0]   ptr;
  logic [CR_W-1:0]   credits;
  logic [CR_W-1:0]   inflight  [N_CH];
  logic [BANK_W-1:0] bank      [N_CH];
  logic [BANK_W-1:0] pend_bank [N_CH];
  logic [N_CH-1:0]   pending;
  logic [DATA_W-1:0] fq_data   [MAX_INFLIGHT];
  logic [CH_W-1:0]   fq_ch     [MAX_INFLIGHT];
  logic [FA_W-1:0]   rd_ptr;
  logic [FA_W-1:0]   wr_ptr;
  logic [CR_W-1:0]   count;
  logic [GD_W-1:0]   guard;

  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   grant;
  logic [N_CH-1:0]   dec_v;
  logic [CH_W-1:0]   gidx;
  logic              found;
  logic              can_issue;
  logic              issue;
  logic              push;
  logic              pop;
  logic              full;
  logic              drop;
  logic              spur;

  function automatic logic [FA_W-1:0] nxt(input logic [FA_W-1:0] p);
    return (p == FA_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign elig      = i_ch_valid & ~pending;
  assign can_issue = ~i_rst & i_hp_ready & (credits != '0);

  always_comb begin
    int j;
    gidx  = '0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      j = (int'(ptr) + i) % N_CH;
      if (!found && elig[j]) begin
        found = 1'b1;
        gidx  = CH_W'(j);
      end
    end
    if (found && can_issue) grant[gidx] = 1'b1;
  end

  assign o_ch_ready = grant;
  assign issue      = found & can_issue;

  // Returns inside the post-reset guard window belong to the old epoch.
  assign push = i_hp_valid & (guard == '0);
  assign pop  = o_out_valid & i_out_ready;
  assign full = (count == CR_W'(MAX_INFLIGHT));
  assign drop = push & full & ~pop;
  assign spur = push & (inflight[i_hp_ch] == '0);

  always_comb begin
    dec_v = '0;
    for (int k = 0; k < N_CH; k++)
      dec_v[k] = push && (i_hp_ch == CH_W'(k)) && (inflight[k] != '0);
  end

  assign o_out_valid = (count != '0);
  assign o_out_data  = fq_data[rd_ptr];
  assign o_out_ch    = fq_ch[rd_ptr];
  assign o_cfg_busy  = |pending;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr        <= '0;
      credits    <= CR_W'(MAX_INFLIGHT);
      pending    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      guard      <= GD_W'(HP_LAT);
      o_hp_valid <= 1'b0;
      o_hp_data  <= '0;
      o_hp_ch    <= '0;
      o_hp_bank  <= '0;
      o_err      <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        inflight[k]  <= '0;
        bank[k]      <= '0;
        pend_bank[k] <= '0;
      end
      for (int k = 0; k < MAX_INFLIGHT; k++) begin
        fq_data[k] <= '0;
        fq_ch[k]   <= '0;
      end
    end else begin
      if (guard != '0) guard <= guard - 1'b1;

      o_hp_valid <= issue;
      if (issue) begin
        ptr       <= (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
        o_hp_data <= i_ch_data[gidx*DATA_W +: DATA_W];
        o_hp_ch   <= gidx;
        o_hp_bank <= bank[gidx];
      end

      // Credits return on pop; saturate so spurious traffic cannot wrap.
      if (issue && !pop)
        credits <= credits - 1'b1;
      else if (pop && !issue && credits != CR_W'(MAX_INFLIGHT))
        credits <= credits + 1'b1;

      for (int k = 0; k < N_CH; k++)
        inflight[k] <= inflight[k] + CR_W'(grant[k]) - CR_W'(dec_v[k]);

      if (push && !drop) begin
        fq_data[wr_ptr] <= i_hp_data;
        fq_ch[wr_ptr]   <= i_hp_ch;
        wr_ptr          <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CR_W'(push && !drop) - CR_W'(pop);

      if (drop || spur) o_err <= 1'b1;

      // A new write beats a same-cycle apply; apply waits for a drain.
      for (int k = 0; k < N_CH; k++) begin
        if (i_cfg_we && i_cfg_ch == CH_W'(k)) begin
          pending[k]   <= 1'b1;
          pend_bank[k] <= i_cfg_bank;
        end else if (pending[k] && inflight[k] == '0) begin
          bank[k]    <= pend_bank[k];
          pending[k] <= 1'b0;
        end
      end
    end
  end

endmodule
